// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-requester LSU arbiter.
// Holds the FSM state encoding, the LSU data-type codes and the PRIO_MODE encodings.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [1:0] DT_W  = 2'b00;
  localparam logic [1:0] DT_HW = 2'b01;
  localparam logic [1:0] DT_B  = 2'b10;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [1:0]  dtype;
    logic        uns;
  } cmd_t;

  // The reserved type code 11 is forwarded to the LSU as a word access.
  function automatic logic dtype_valid(input logic [1:0] t);
    return (t == DT_W) || (t == DT_HW) || (t == DT_B);
  endfunction

endpackage

// File: rtl/lsu_arb_pick.sv
// Combinational winner selection for two requesters.
// last=1 means m1 won most recently; prio_mode=1 gives m0 fixed priority.
module lsu_arb_pick
  import lsu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_mode,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default before the case so every path assigns gnt and no latch is inferred.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio_mode || last) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-requester arbiter in front of a single shared LSU: IDLE -> ISSUE -> RESP.
// Optional m1 grant lock is built only when macro LSU_ARB_LOCK_EN is defined.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m0_wren,
  input  logic [1:0]  i_m0_type,
  input  logic        i_m0_unsigned,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic        i_m1_wren,
  input  logic [1:0]  i_m1_type,
  input  logic        i_m1_unsigned,
  input  logic        i_m1_lock,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic        o_unsigned,
  output logic [1:0]  o_data_type,
  input  logic [31:0] i_ld_data
);

  state_e     state;
  logic       last;   // 1: m1 won the most recent grant
  logic       sel;    // owner of the command in flight
  logic [1:0] req;
  logic [1:0] pick_gnt;
  logic [1:0] win;
  cmd_t       cmd;

  assign req = {i_m1_req, i_m0_req};

  lsu_arb_pick u_pick (
    .req       (req),
    .last      (last),
    .prio_mode (PRIO_MODE == PRIO_FIXED),
    .gnt       (pick_gnt)
  );

`ifdef LSU_ARB_LOCK_EN
  logic lock;
  assign win = (lock && req[1]) ? 2'b10 : pick_gnt;
`else
  logic unused_lock;
  assign unused_lock = i_m1_lock;
  assign win = pick_gnt;
`endif

  always_comb begin
    cmd = '0;
    if (win[1]) begin
      cmd = '{addr: i_m1_addr, wdata: i_m1_wdata, wren: i_m1_wren,
              dtype: i_m1_type, uns: i_m1_unsigned};
    end else begin
      cmd = '{addr: i_m0_addr, wdata: i_m0_wdata, wren: i_m0_wren,
              dtype: i_m0_type, uns: i_m0_unsigned};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      sel         <= 1'b0;
      o_m0_gnt    <= 1'b0;
      o_m1_gnt    <= 1'b0;
      o_m0_rvalid <= 1'b0;
      o_m1_rvalid <= 1'b0;
      o_m0_rdata  <= '0;
      o_m1_rdata  <= '0;
      o_lsu_addr  <= '0;
      o_st_data   <= '0;
      o_lsu_wren  <= 1'b0;
      o_unsigned  <= 1'b0;
      o_data_type <= DT_W;
`ifdef LSU_ARB_LOCK_EN
      lock        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= ISSUE;
            sel         <= win[1];
            last        <= win[1];
            o_m0_gnt    <= win[0];
            o_m1_gnt    <= win[1];
            o_lsu_addr  <= cmd.addr;
            o_st_data   <= cmd.wdata;
            o_lsu_wren  <= cmd.wren;
            o_unsigned  <= cmd.uns;
            o_data_type <= dtype_valid(cmd.dtype) ? cmd.dtype : DT_W;
          end
`ifdef LSU_ARB_LOCK_EN
          // m0 can only win while m1 is requesting if the lock is already clear.
          if (!req[1]) begin
            lock <= 1'b0;
          end else if (win[1]) begin
            lock <= i_m1_lock;
          end
`endif
        end
        ISSUE: begin
          state      <= RESP;
          o_m0_gnt   <= 1'b0;
          o_m1_gnt   <= 1'b0;
          o_lsu_wren <= 1'b0;
          if (sel) begin
            o_m1_rvalid <= 1'b1;
            o_m1_rdata  <= o_lsu_wren ? 32'd0 : i_ld_data;
          end else begin
            o_m0_rvalid <= 1'b1;
            o_m0_rdata  <= o_lsu_wren ? 32'd0 : i_ld_data;
          end
        end
        RESP: begin
          state       <= IDLE;
          o_m0_rvalid <= 1'b0;
          o_m1_rvalid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed self-checking bench for lsu_arbiter: round-robin instance plus a fixed-priority
// instance on shared stimulus. Expected lock behaviour follows LSU_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_lsu_arbiter;
  import lsu_arb_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_req, i_m0_wren, i_m0_unsigned;
  logic [31:0] i_m0_addr, i_m0_wdata;
  logic [1:0]  i_m0_type;
  logic        i_m1_req, i_m1_wren, i_m1_unsigned, i_m1_lock;
  logic [31:0] i_m1_addr, i_m1_wdata;
  logic [1:0]  i_m1_type;
  logic [31:0] i_ld_data;

  logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
  logic [31:0] o_m0_rdata, o_m1_rdata, o_lsu_addr, o_st_data;
  logic        o_lsu_wren, o_unsigned;
  logic [1:0]  o_data_type;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_lsu_addr, fp_st_data;
  logic        fp_lsu_wren, fp_unsigned;
  logic [1:0]  fp_data_type;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  lsu_arbiter #(.PRIO_MODE(PRIO_RR)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .i_m0_wren(i_m0_wren), .i_m0_type(i_m0_type), .i_m0_unsigned(i_m0_unsigned),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .i_m1_wren(i_m1_wren), .i_m1_type(i_m1_type), .i_m1_unsigned(i_m1_unsigned),
    .i_m1_lock(i_m1_lock),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data), .o_lsu_wren(o_lsu_wren),
    .o_unsigned(o_unsigned), .o_data_type(o_data_type), .i_ld_data(i_ld_data)
  );

  lsu_arbiter #(.PRIO_MODE(PRIO_FIXED)) dut_fp (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .i_m0_wren(i_m0_wren), .i_m0_type(i_m0_type), .i_m0_unsigned(i_m0_unsigned),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .i_m1_wren(i_m1_wren), .i_m1_type(i_m1_type), .i_m1_unsigned(i_m1_unsigned),
    .i_m1_lock(i_m1_lock),
    .o_m0_gnt(fp_m0_gnt), .o_m0_rvalid(fp_m0_rvalid), .o_m0_rdata(fp_m0_rdata),
    .o_m1_gnt(fp_m1_gnt), .o_m1_rvalid(fp_m1_rvalid), .o_m1_rdata(fp_m1_rdata),
    .o_lsu_addr(fp_lsu_addr), .o_st_data(fp_st_data), .o_lsu_wren(fp_lsu_wren),
    .o_unsigned(fp_unsigned), .o_data_type(fp_data_type), .i_ld_data(i_ld_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wren, input logic [1:0] dtype, input logic uns);
    i_m0_req = req; i_m0_addr = addr; i_m0_wdata = wdata;
    i_m0_wren = wren; i_m0_type = dtype; i_m0_unsigned = uns;
  endtask

  task automatic set_m1(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wren, input logic [1:0] dtype, input logic uns,
                        input logic lock);
    i_m1_req = req; i_m1_addr = addr; i_m1_wdata = wdata;
    i_m1_wren = wren; i_m1_type = dtype; i_m1_unsigned = uns; i_m1_lock = lock;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    tick();
    tick();
    check("rst_gnt",    32'({o_m1_gnt, o_m0_gnt}), 32'd0);
    check("rst_rvalid", 32'({o_m1_rvalid, o_m0_rvalid}), 32'd0);
    check("rst_rdata0", o_m0_rdata, 32'd0);
    check("rst_rdata1", o_m1_rdata, 32'd0);
    check("rst_wren",   32'(o_lsu_wren), 32'd0);
    check("rst_addr",   o_lsu_addr, 32'd0);
    i_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0]  exp_m1_tab;
    logic [31:0] exp_addr_tab [4];
    int          m1_stage;

    set_m0(1'b0, '0, '0, 1'b0, DT_W, 1'b0);
    set_m1(1'b0, '0, '0, 1'b0, DT_W, 1'b0, 1'b0);
    i_ld_data = 32'hDEAD_BEEF;
    apply_reset();

    // Single m0 word load.
    set_m0(1'b1, 32'h2004, '0, 1'b0, DT_W, 1'b0);
    tick();
    check("ld_gnt0",  32'(o_m0_gnt), 32'd1);
    check("ld_gnt1",  32'(o_m1_gnt), 32'd0);
    check("ld_addr",  o_lsu_addr, 32'h2004);
    check("ld_wren",  32'(o_lsu_wren), 32'd0);
    check("ld_rv0_early", 32'(o_m0_rvalid), 32'd0);
    set_m0(1'b0, 32'h2004, '0, 1'b0, DT_W, 1'b0);
    tick();
    check("ld_rv0",   32'(o_m0_rvalid), 32'd1);
    check("ld_rdata", o_m0_rdata, 32'hDEAD_BEEF);
    check("ld_gnt0_off", 32'(o_m0_gnt), 32'd0);
    check("ld_side1", 32'({o_m1_gnt, o_m1_rvalid}), 32'd0);
    tick();
    check("ld_rv0_off", 32'(o_m0_rvalid), 32'd0);
    check("ld_hold",  o_m0_rdata, 32'hDEAD_BEEF);

    // Round-robin on dut, fixed priority on dut_fp, both requesters holding req.
    apply_reset();
    set_m0(1'b1, 32'h100, '0, 1'b0, DT_W, 1'b0);
    set_m1(1'b1, 32'h200, '0, 1'b0, DT_HW, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic exp_m1;
      exp_m1 = k[0];
      tick();
      check("rr_gnt0", 32'(o_m0_gnt), 32'(!exp_m1));
      check("rr_gnt1", 32'(o_m1_gnt), 32'(exp_m1));
      check("rr_addr", o_lsu_addr, exp_m1 ? 32'h200 : 32'h100);
      check("fp_gnt",  32'({fp_m1_gnt, fp_m0_gnt}), 32'd1);
      i_ld_data = 32'h1000 + 32'(k);
      tick();
      check("rr_rv0", 32'(o_m0_rvalid), 32'(!exp_m1));
      check("rr_rv1", 32'(o_m1_rvalid), 32'(exp_m1));
      check("rr_rdata", exp_m1 ? o_m1_rdata : o_m0_rdata, 32'h1000 + 32'(k));
      check("fp_rv1", 32'(fp_m1_rvalid), 32'd0);
      tick();
      check("rr_idle", 32'({o_m1_gnt, o_m0_gnt}), 32'd0);
    end

    // m1 byte store; previous m1 rdata was 0x1003 and must become 0.
    set_m0(1'b0, 32'h100, '0, 1'b0, DT_W, 1'b0);
    set_m1(1'b1, 32'h7020, 32'h0000_00A5, 1'b1, DT_B, 1'b0, 1'b0);
    i_ld_data = 32'hCAFE_F00D;
    tick();
    check("st_gnt1",  32'(o_m1_gnt), 32'd1);
    check("st_wren",  32'(o_lsu_wren), 32'd1);
    check("st_type",  32'(o_data_type), 32'(DT_B));
    check("st_data",  o_st_data, 32'h0000_00A5);
    check("st_addr",  o_lsu_addr, 32'h7020);
    i_m1_req = 1'b0;
    tick();
    check("st_wren_off", 32'(o_lsu_wren), 32'd0);
    check("st_rv1",   32'(o_m1_rvalid), 32'd1);
    check("st_rdata", o_m1_rdata, 32'd0);
    tick();
    check("st_wren_idle", 32'(o_lsu_wren), 32'd0);
    check("st_rv1_off", 32'(o_m1_rvalid), 32'd0);

    // m1 load+lock then store while m0 requests throughout.
    apply_reset();
`ifdef LSU_ARB_LOCK_EN
    exp_m1_tab   = 4'b0110;
    exp_addr_tab = '{32'h300, 32'h400, 32'h404, 32'h300};
`else
    exp_m1_tab   = 4'b1010;
    exp_addr_tab = '{32'h300, 32'h400, 32'h300, 32'h404};
`endif
    m1_stage = 0;
    set_m0(1'b1, 32'h300, '0, 1'b0, DT_W, 1'b0);
    set_m1(1'b1, 32'h400, '0, 1'b0, DT_W, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("lk_gnt1", 32'(o_m1_gnt), 32'(exp_m1_tab[k]));
      check("lk_gnt0", 32'(o_m0_gnt), 32'(!exp_m1_tab[k]));
      check("lk_addr", o_lsu_addr, exp_addr_tab[k]);
      if (o_m1_gnt) begin
        m1_stage++;
        if (m1_stage == 1) set_m1(1'b1, 32'h404, 32'h5A5A_5A5A, 1'b1, DT_W, 1'b0, 1'b0);
        else               i_m1_req = 1'b0;
      end
      tick();
      tick();
    end
    i_m0_req = 1'b0;
    i_m1_req = 1'b0;

    // Reset pulse during ISSUE of an m0 store.
    apply_reset();
    set_m0(1'b1, 32'h500, 32'h11, 1'b1, DT_W, 1'b0);
    tick();
    check("ri_gnt0", 32'(o_m0_gnt), 32'd1);
    check("ri_wren", 32'(o_lsu_wren), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("ri_wren_async", 32'(o_lsu_wren), 32'd0);
    check("ri_gnt_async",  32'({o_m1_gnt, o_m0_gnt}), 32'd0);
    i_rst = 1'b0;
    set_m1(1'b1, 32'h600, '0, 1'b0, DT_W, 1'b0, 1'b0);
    tick();
    check("ri_no_rv", 32'({o_m1_rvalid, o_m0_rvalid}), 32'd0);
    check("ri_tie",   32'({o_m1_gnt, o_m0_gnt}), 32'd1);
    check("ri_addr",  o_lsu_addr, 32'h500);
    i_m0_req = 1'b0;
    i_m1_req = 1'b0;
    tick();
    check("ri_rv0",    32'(o_m0_rvalid), 32'd1);
    check("ri_rdata0", o_m0_rdata, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
